// File: rtl/subtractor_nibble_serial_16b.sv
// Nibble-serial 16-bit unsigned subtractor: diff = in0 - in1 - bin, one nibble
// per cycle through a single gate-level 4-bit ripple-borrow subtractor.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_val/in_rdy     operand handshake (in0, in1, bin sampled on acceptance)
//   out_val/out_rdy   result handshake (diff, bout held while out_val)
//   diff[15:0], bout  result and final borrow-out

// Gate-level 4-bit ripple-borrow subtractor: {bout, diff} = in0 - in1 - bin.
module SubtractorRippleCarry_4b_GL (
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic [4:0] brw;
  logic [3:0] axb;

  assign brw[0] = bin;

  // Full-subtractor cell per bit.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign axb[i]    = in0[i] ^ in1[i];
    assign diff[i]   = axb[i] ^ brw[i];
    assign brw[i+1]  = (~in0[i] & in1[i]) | (~axb[i] & brw[i]);
  end

  assign bout = brw[4];

endmodule

module subtractor_nibble_serial_16b (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic        bin,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [15:0] diff,
  output logic        bout
);

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NIB_W-1:0]   nibble_diff;
  logic               nibble_bout;

  // Low nibble of each operand plus the running borrow feed the subtractor.
  SubtractorRippleCarry_4b_GL u_sub (
    .in0  (a_q[NIB_W-1:0]),
    .in1  (b_q[NIB_W-1:0]),
    .bin  (borrow_q),
    .diff (nibble_diff),
    .bout (nibble_bout)
  );

  // Control and datapath state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_val) begin
            a_q      <= in0;
            b_q      <= in1;
            borrow_q <= bin;
            cnt_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          // Results enter at the top so the first nibble ends up in bits [3:0].
          res_q    <= {nibble_diff, res_q[WIDTH-1:NIB_W]};
          a_q      <= a_q >> NIB_W;
          b_q      <= b_q >> NIB_W;
          borrow_q <= nibble_bout;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(3)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_rdy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state; reset masks them in its own cycle.
  assign in_rdy  = !rst && (state_q == IDLE);
  assign out_val = !rst && (state_q == DONE);
  assign diff    = rst ? '0 : res_q;
  assign bout    = !rst && borrow_q;

endmodule

// File: tb/tb_subtractor_nibble_serial_16b.sv
// Directed self-checking bench for subtractor_nibble_serial_16b.
module tb_subtractor_nibble_serial_16b;

  logic        clk;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        bin;
  logic        out_val;
  logic        out_rdy;
  logic [15:0] diff;
  logic        bout;

  int checks;
  int errors;

  subtractor_nibble_serial_16b dut (
    .clk     (clk),
    .rst     (rst),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in0     (in0),
    .in1     (in1),
    .bin     (bin),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .diff    (diff),
    .bout    (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accepting edge; returns in the cycle after it.
  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic bi);
    in0    = a;
    in1    = b;
    bin    = bi;
    in_val = 1'b1;
    tick();
    in_val = 1'b0;
    in0    = 16'hDEAD;
    in1    = 16'hBEEF;
    bin    = 1'b1;
  endtask

  // Wait (bounded) for out_val; ok=0 on timeout.
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_val === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_val = 1'b0; out_rdy = 1'b1;
    in0 = '0; in1 = '0; bin = 1'b0;
    tick();
    tick();
    checks++;
    if ({in_rdy, out_val, bout, diff} !== 19'h0) begin
      errors++;
      $display("FAIL reset_held: in_rdy=%b out_val=%b bout=%b diff=%h, required all 0",
               in_rdy, out_val, bout, diff);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0 || diff !== 16'h0 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_rdy=%b out_val=%b diff=%h bout=%b, required 1 0 0000 0",
               in_rdy, out_val, diff, bout);
    end
  endtask

  task automatic test_basic();
    out_rdy = 1'b1;
    accept(16'h1234, 16'h0234, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (in_rdy !== 1'b0 || out_val !== 1'b0) begin
        errors++;
        $display("FAIL basic_calc_E+%0d: in_rdy=%b out_val=%b, required 0 0", k, in_rdy, out_val);
      end
      tick();
    end
    checks++;
    if (out_val !== 1'b1 || in_rdy !== 1'b0 || diff !== 16'h1000 || bout !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_E+5: out_val=%b in_rdy=%b diff=%h bout=%b, required 1 0 1000 0",
               out_val, in_rdy, diff, bout);
    end
    tick();
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
      errors++;
      $display("FAIL basic_E+6: in_rdy=%b out_val=%b, required 1 0", in_rdy, out_val);
    end
  endtask

  // Run a full operation with out_rdy=1 and check the delivered result.
  task automatic test_vector(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic bi, input logic [15:0] exp_d, input logic exp_b);
    bit ok;
    out_rdy = 1'b1;
    accept(a, b, bi);
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: out_val never rose, required 1", name);
    end else if (diff !== exp_d || bout !== exp_b) begin
      errors++;
      $display("FAIL %s: diff=%h bout=%b, required diff=%h bout=%b", name, diff, bout, exp_d, exp_b);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    accept(16'hA5A5, 16'h5A5A, 1'b0);
    for (int k = 1; k <= 4; k++) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_val !== 1'b1 || in_rdy !== 1'b0 || diff !== 16'h4B4B || bout !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_val=%b in_rdy=%b diff=%h bout=%b, required 1 0 4b4b 0",
                 i, out_val, in_rdy, diff, bout);
      end
      if (i == 1) begin
        in0 = 16'h0001; in1 = 16'h0000; bin = 1'b0; in_val = 1'b1;
      end else begin
        in_val = 1'b0;
      end
      if (i == 3) out_rdy = 1'b1;
      tick();
    end
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_val=%b in_rdy=%b, required 0 1", out_val, in_rdy);
    end
    tick();
    checks++;
    if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_ignored_pulse: out_val=%b in_rdy=%b, required 0 1", out_val, in_rdy);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    out_rdy = 1'b1;
    accept(16'h1111, 16'h2222, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({in_rdy, out_val, bout, diff} !== 19'h0) begin
      errors++;
      $display("FAIL rstmid_forced: in_rdy=%b out_val=%b bout=%b diff=%h, required all 0",
               in_rdy, out_val, bout, diff);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0 || diff !== 16'h0 || bout !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: in_rdy=%b out_val=%b diff=%h bout=%b, required 1 0 0000 0",
               in_rdy, out_val, diff, bout);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_val === 1'b1 || in_rdy !== 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rstmid_discarded: %0d cycles left IDLE, required 0", seen);
    end
    test_vector("rstmid_followup", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0);
  endtask

  task automatic test_rst_vs_handshake();
    out_rdy = 1'b1;
    in0 = 16'h0005; in1 = 16'h0003; bin = 1'b0;
    in_val = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_val = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
      errors++;
      $display("FAIL rst_wins_accept: in_rdy=%b out_val=%b, required 1 0", in_rdy, out_val);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_vector("full_ripple",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    test_vector("bin_consumed",   16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0);
    test_vector("bin_overflow",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    test_vector("mixed_nibbles",  16'h5A3C, 16'h1E47, 1'b0, 16'h3BF5, 1'b0);
    test_backpressure();
    test_reset_mid();
    test_rst_vs_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
